mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
- Initiator on the core-side req/gnt/rvalid memory protocol: the requester end of the port that the RAM arbiter serves.
- Accepts a burst command (start address, word count) and issues sequential word reads.
- Returns the read data on a valid/ready stream with a last flag.
- Sits in front of an arbiter port as a lightweight read-DMA feeding accelerators from data RAM.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; must be 32 or 64
- LEN_WIDTH, 16, width of the burst length field in words
- FIFO_DEPTH, 4, return buffer entries; power of 2, >= 2; also the outstanding-request limit

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid_i  in  1  burst command valid
- cmd_ready_o  out  1  command accepted when both valid and ready are high; high only in IDLE
- cmd_addr_i  in  ADDR_WIDTH  start byte address; low log2(DATA_WIDTH/8) bits ignored
- cmd_len_i  in  LEN_WIDTH  number of words; 0 is legal
- busy_o  out  1  high from command accept until done
- done_o  out  1  one-cycle pulse at burst completion
- mem_req_o  out  1  memory request
- mem_gnt_i  in  1  request granted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_addr_o  out  ADDR_WIDTH  word-aligned request address
- mem_we_o  out  1  constant 0
- mem_be_o  out  DATA_WIDTH/8  constant all-ones
- mem_rdata_i  in  DATA_WIDTH  read data
- out_valid_o  out  1  stream valid
- out_ready_i  in  1  stream ready
- out_data_o  out  DATA_WIDTH  stream data
- out_last_o  out  1  marks the final word of the burst

Behaviour:
- Reset values:
  - state IDLE.
  - cmd_ready_o=1, busy_o=0, done_o=0, mem_req_o=0, mem_addr_o=0, out_valid_o=0, out_last_o=0.
  - FIFO empty; all counters 0.
- Protocol rules:
  - Once mem_req_o is asserted, it and mem_addr_o hold stable until the cycle mem_gnt_i=1.
  - A request completes in the cycle mem_req_o & mem_gnt_i.
  - rvalid arrives in order, >= 1 cycle after its grant (1 cycle for the RAM arbiter).
  - rvalid cannot be stalled.
- Credit rule:
  - mem_req_o may be asserted only when outstanding + fifo_count < FIFO_DEPTH.
  - This guarantees every rvalid finds a free FIFO slot; overflow is impossible by construction.
  - outstanding increments on grant and decrements on rvalid. Both in the same cycle leave it unchanged.
- Address generation:
  - Next address = current + DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH with no error.
  - Back-to-back grants produce one request per cycle.
- States:
  - IDLE: cmd_ready_o=1.
    - On accept with len=0 -> DONE.
    - On accept with len>0 -> REQ. Latch addr, set req_left=len and ret_left=len.
  - REQ: assert mem_req_o when credit is available. Decrement req_left on each grant. After the grant that takes req_left to 0 -> DRAIN.
  - DRAIN: no requests. Wait until every word has been popped from the output stream (ret_left reaches 0) -> DONE.
  - DONE: done_o=1 for exactly one cycle -> IDLE. busy_o drops in the same cycle IDLE is entered.
- Output stream:
  - out_valid_o = FIFO not empty; out_data_o = FIFO head.
  - ret_left decrements on each out_valid_o & out_ready_i.
  - out_last_o = out_valid_o & (ret_left==1).
  - out_data_o must not change while out_valid_o=1 and out_ready_i=0.
- FIFO timing:
  - Push on mem_rvalid_i. rdata is visible on the output the cycle after rvalid (registered FIFO; no combinational rvalid->out path).
  - Simultaneous push and pop when full is allowed and keeps the count unchanged.
- Reset mid-burst:
  - All state is cleared immediately, asynchronously.
  - rvalid arriving after reset while outstanding=0 is dropped.
- Commands presented while not in IDLE are not accepted (cmd_ready_o=0).

Decomposition:
- Package mem_burst_pkg:
  - state enum {IDLE, REQ, DRAIN, DONE}
  - constant BYTES_PER_WORD = DATA_WIDTH/8
  - function for credit width = $clog2(FIFO_DEPTH)+1
- One sub-module: burst_rd_fifo.
  - Synchronous FIFO with DEPTH and WIDTH parameters.
  - Ports: push, pop, data in/out, empty, full, count.
  - Same clk/rst convention.

Test Plan:
- Single-word burst: addr=0x100, len=1, gnt immediate -> one req with mem_addr_o=0x100. Then out_data with out_last_o=1, done_o pulse, busy_o low.
- Streaming burst: len=8, DATA_WIDTH=32, gnt always high, out_ready_i=1 -> addresses 0x0..0x1C on consecutive cycles. Eight outputs in order; last only on the 8th word.
- Backpressure: len=16, out_ready_i=0 -> at most FIFO_DEPTH(4) grants, then mem_req_o low. Release ready -> all 16 words in order, none lost.
- Grant stall: gnt withheld for 5 cycles -> mem_req_o and mem_addr_o stable for all 5 cycles; rvalid latency randomized 1-3 cycles -> data order preserved.
- Wrap and zero length:
  - addr=0xFFFFFFF8, len=4 -> addresses FFFFFFF8, FFFFFFFC, 0, 4.
  - len=0 -> no mem_req_o; done_o pulse 1 cycle after accept.
- Reset mid-burst: assert rst with 2 requests outstanding -> all outputs at reset values immediately. Stray rvalid afterwards does not raise out_valid_o.

Source files
------------

// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state type and sizing helpers for the burst reader
package mem_burst_pkg;
   typedef enum logic [1:0] {IDLE, REQ, DRAIN, DONE} state_t;
   function automatic int bytes_per_word(int data_width);
      return data_width / 8;
   endfunction
   function automatic int credit_width(int fifo_depth);
      return $clog2(fifo_depth) + 1;
   endfunction
endpackage

// File: rtl/burst_rd_fifo.sv
// burst_rd_fifo: registered FIFO holding read returns until the stream consumer takes them
module burst_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic do_push, do_pop;
   assign empty = count == '0;
   assign full = count == (AW+1)'(DEPTH);
   assign do_pop = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout = mem[rd_ptr];
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(do_push);
         rd_ptr <= rd_ptr + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/mem_burst_reader.sv
// mem_burst_reader: read-DMA issuing sequential word reads on a req/gnt/rvalid port into a valid/ready stream
module mem_burst_reader
   import mem_burst_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [LEN_WIDTH-1:0]    cmd_len_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    mem_req_o,
   input  logic                    mem_gnt_i,
   input  logic                    mem_rvalid_i,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic [DATA_WIDTH-1:0]   out_data_o,
   output logic                    out_last_o
);
   localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
   localparam int CW = credit_width(FIFO_DEPTH);
   state_t state, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_WIDTH-1:0] req_left, ret_left;
   logic [CW-1:0] outstanding, fifo_count;
   logic accept, grant, push, pop, empty, full, credit;
   // Outstanding reads plus buffered words never exceed the FIFO, so rvalid always has a slot.
   assign credit = ~full && ({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH);
   assign accept = cmd_valid_i & cmd_ready_o;
   assign grant = mem_req_o & mem_gnt_i;
   assign push = mem_rvalid_i && outstanding != '0;
   assign pop = out_valid_o & out_ready_i;
   assign out_valid_o = ~empty;
   assign out_last_o = out_valid_o && ret_left == LEN_WIDTH'(1);
   assign mem_addr_o = addr_q;
   assign mem_we_o = 1'b0;
   assign mem_be_o = '1;
   always_comb begin
      state_d = state;
      cmd_ready_o = state == IDLE;
      busy_o = state != IDLE;
      done_o = state == DONE;
      mem_req_o = state == REQ && credit;
      unique case (state)
         IDLE:    if (cmd_valid_i) state_d = cmd_len_i == '0 ? DONE : REQ;
         REQ:     if (grant && req_left == LEN_WIDTH'(1)) state_d = DRAIN;
         DRAIN:   if (ret_left == '0) state_d = DONE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         addr_q <= '0;
         req_left <= '0;
         ret_left <= '0;
         outstanding <= '0;
      end else begin
         state <= state_d;
         outstanding <= outstanding + CW'(grant) - CW'(push);
         if (accept) begin
            addr_q <= cmd_addr_i & ~ADDR_WIDTH'(BYTES_PER_WORD - 1);
            req_left <= cmd_len_i;
            ret_left <= cmd_len_i;
         end else begin
            if (grant) addr_q <= addr_q + ADDR_WIDTH'(BYTES_PER_WORD);
            if (grant) req_left <= req_left - LEN_WIDTH'(1);
            if (pop) ret_left <= ret_left - LEN_WIDTH'(1);
         end
      end
   burst_rd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_WIDTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (mem_rdata_i),
      .dout  (out_data_o),
      .empty (empty),
      .full  (full),
      .count (fifo_count)
   );
endmodule

// File: tb/tb_mem_burst_reader.sv
// tb_mem_burst_reader: directed vector table plus hand sequences against a small RAM model
module tb_mem_burst_reader;
   logic clk = 0;
   logic rst = 0;
   logic cmd_valid_i, cmd_ready_o, busy_o, done_o, mem_req_o, mem_gnt_i, mem_we_o;
   logic mem_rvalid_i = 0;
   logic out_valid_o, out_ready_i, out_last_o;
   logic [31:0] cmd_addr_i, mem_addr_o, mem_rdata_i, out_data_o;
   logic [15:0] cmd_len_i;
   logic [3:0] mem_be_o;
   int pass_n = 0, tot_n = 0, cyc = 0, done_cnt = 0, last_due = 0, lat_fix = 1;
   bit lat_rand = 0;
   logic [31:0] pq_addr[$], gq[$], oq_data[$];
   int pq_due[$], gcyc[$];
   logic oq_last[$];
   typedef struct {
      logic [31:0] addr;
      logic [15:0] len;
      bit lat_rand;
      bit rdy_rand;
      bit consec;
      logic [31:0] a0;
      logic [31:0] alast;
      int n;
   } vec_t;
   vec_t vt[6];

   mem_burst_reader dut (
      .clk(clk), .rst(rst), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .busy_o(busy_o), .done_o(done_o),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
      .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_data_o(out_data_o), .out_last_o(out_last_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [31:0] dfun(logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // RAM model: grants are seen mid-cycle, returns are in order with 1..3 cycle latency.
   always @(negedge clk) begin : mem_model
      int lat;
      int due;
      mem_rvalid_i = 0;
      if (pq_due.size() > 0 && pq_due[0] == cyc) begin
         mem_rvalid_i = 1;
         mem_rdata_i = dfun(pq_addr[0]);
         void'(pq_addr.pop_front());
         void'(pq_due.pop_front());
      end
      if (mem_req_o && mem_gnt_i) begin
         lat = lat_rand ? int'($urandom_range(3, 1)) : lat_fix;
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pq_addr.push_back(mem_addr_o);
         pq_due.push_back(due);
         gq.push_back(mem_addr_o);
         gcyc.push_back(cyc);
      end
      if (out_valid_o && out_ready_i) begin
         oq_data.push_back(out_data_o);
         oq_last.push_back(out_last_o);
      end
      if (done_o) done_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic start_cmd(input logic [31:0] a, input logic [15:0] l);
      gq.delete(); gcyc.delete(); oq_data.delete(); oq_last.delete();
      done_cnt = 0;
      cmd_addr_i = a;
      cmd_len_i = l;
      cmd_valid_i = 1;
      @(posedge clk); #1;
      cmd_valid_i = 0;
   endtask

   task automatic wait_done(input bit rrand);
      int n = 0;
      while (done_cnt == 0 && n < 600) begin
         @(posedge clk); #1;
         if (rrand) out_ready_i = 1'($urandom_range(1, 0));
         n++;
      end
      @(posedge clk); #1;
      out_ready_i = 1;
      chk("done_once", done_cnt, 1);
      chk("busy_after", busy_o, 0);
   endtask

   task automatic check_words(input string tag, input logic [31:0] a0, input int n);
      int bad = 0, badl = 0;
      chk({tag, "_count"}, oq_data.size(), n);
      for (int i = 0; i < oq_data.size(); i++) begin
         if (oq_data[i] !== dfun(a0 + 32'(4 * i))) bad++;
         if (oq_last[i] !== (i == n - 1)) badl++;
      end
      chk({tag, "_data"}, bad, 0);
      chk({tag, "_last"}, badl, 0);
   endtask

   initial begin
      int n, seen;
      logic [31:0] d0;
      cmd_valid_i = 0; cmd_addr_i = 0; cmd_len_i = 0; mem_gnt_i = 1; out_ready_i = 1; mem_rdata_i = 0;
      vt[0] = '{32'h0000_0100, 16'd1,  1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0100, 1};
      vt[1] = '{32'h0000_0000, 16'd8,  1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0000_001C, 8};
      vt[2] = '{32'h0000_1003, 16'd3,  1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_1008, 3};
      vt[3] = '{32'hFFFF_FFF8, 16'd4,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0000_0004, 4};
      vt[4] = '{32'h0000_0040, 16'd16, 1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_007C, 16};
      vt[5] = '{32'h0000_0700, 16'd0,  1'b0, 1'b0, 1'b0, 32'h0000_0700, 32'h0000_0700, 0};
      #1 rst = 1;
      #2;
      chk("rst_cmd_ready", cmd_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_out_valid", out_valid_o, 0);
      chk("rst_out_last", out_last_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_be", mem_be_o, 4'hF);
      @(posedge clk); @(posedge clk); #1 rst = 0;
      @(posedge clk); #1;

      start_cmd(32'h500, 16'd0);
      chk("zl_done", done_o, 1);
      chk("zl_busy_hi", busy_o, 1);
      chk("zl_req", mem_req_o, 0);
      @(posedge clk); #1;
      chk("zl_done_drop", done_o, 0);
      chk("zl_busy", busy_o, 0);
      chk("zl_ready", cmd_ready_o, 1);
      chk("zl_nreq", gq.size(), 0);

      out_ready_i = 0;
      start_cmd(32'h200, 16'd16);
      repeat (12) @(posedge clk);
      #1;
      chk("bp_grants", gq.size(), 4);
      chk("bp_req_low", mem_req_o, 0);
      chk("bp_valid", out_valid_o, 1);
      chk("bp_head", out_data_o, dfun(32'h200));
      d0 = out_data_o;
      repeat (2) @(posedge clk);
      #1;
      chk("bp_stable", out_data_o, d0);
      chk("bp_last", out_last_o, 0);
      out_ready_i = 1;
      wait_done(0);
      check_words("bp", 32'h200, 16);

      mem_gnt_i = 0;
      lat_rand = 1;
      start_cmd(32'h300, 16'd3);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", mem_req_o, 1);
         chk("stall_addr", mem_addr_o, 32'h300);
         @(posedge clk); #1;
      end
      chk("stall_nogrant", gq.size(), 0);
      mem_gnt_i = 1;
      wait_done(0);
      check_words("stall", 32'h300, 3);
      lat_rand = 0;

      lat_fix = 3;
      out_ready_i = 0;
      start_cmd(32'h600, 16'd8);
      n = 0;
      while (gq.size() < 2 && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      chk("mr_two_grants", gq.size(), 2);
      rst = 1;
      #1;
      chk("mr_cmd_ready", cmd_ready_o, 1);
      chk("mr_busy", busy_o, 0);
      chk("mr_req", mem_req_o, 0);
      chk("mr_addr", mem_addr_o, 0);
      chk("mr_out_valid", out_valid_o, 0);
      @(posedge clk); #1 rst = 0;
      seen = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (out_valid_o) seen++;
      end
      chk("mr_stray_dropped", seen, 0);
      chk("mr_idle", cmd_ready_o, 1);
      lat_fix = 1;
      out_ready_i = 1;

      for (int k = 0; k < 6; k++) begin
         lat_rand = vt[k].lat_rand;
         chk($sformatf("v%0d_ready", k), cmd_ready_o, 1);
         start_cmd(vt[k].addr, vt[k].len);
         wait_done(vt[k].rdy_rand);
         chk($sformatf("v%0d_nreq", k), gq.size(), vt[k].n);
         if (vt[k].n > 0) begin
            chk($sformatf("v%0d_a0", k), gq[0], vt[k].a0);
            chk($sformatf("v%0d_alast", k), gq[gq.size() - 1], vt[k].alast);
         end
         if (vt[k].consec) chk($sformatf("v%0d_consec", k), gcyc[gcyc.size() - 1] - gcyc[0], vt[k].n - 1);
         check_words($sformatf("v%0d", k), vt[k].a0, vt[k].n);
      end

      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
